// File: rtl/game_judge.sv
// Tic-tac-toe judge: snapshots the board on every change, scans the eight
// winning lines one per cycle, and reports a win, a draw or game over.
module game_judge #(
    parameter int WIN_HOLD = 4
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       start_en,
    input  logic [8:0] square1to9,
    input  logic [8:0] square1to9_color,
    output logic       move_pulse,
    output logic [3:0] move_cnt,
    output logic       busy,
    output logic       winner_valid,
    output logic       winner,
    output logic [2:0] win_line,
    output logic       draw,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SCAN,
        S_HOLD,
        S_OVER
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(WIN_HOLD - 1);
    localparam logic [2:0] LAST_LINE = 3'd7;

    state_t     state_q, state_d;
    logic [8:0] snap_occ_q, snap_occ_d;
    logic [8:0] snap_col_q, snap_col_d;
    logic [2:0] line_q, line_d;
    logic [7:0] hold_q, hold_d;
    logic       move_pulse_q, move_pulse_d;
    logic [3:0] move_cnt_q, move_cnt_d;
    logic       winner_valid_q, winner_valid_d;
    logic       winner_q, winner_d;
    logic [2:0] win_line_q, win_line_d;
    logic       draw_q, draw_d;
    logic       game_over_q, game_over_d;

    logic [8:0] line_mask;
    logic       line_won;
    logic       line_col;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    // Square membership of each line, bit0 = top-left, row-major.
    function automatic logic [8:0] mask_of(input logic [2:0] k);
        logic [8:0] m;
        case (k)
            3'd0:    m = 9'h007;
            3'd1:    m = 9'h038;
            3'd2:    m = 9'h1C0;
            3'd3:    m = 9'h049;
            3'd4:    m = 9'h092;
            3'd5:    m = 9'h124;
            3'd6:    m = 9'h111;
            default: m = 9'h054;
        endcase
        return m;
    endfunction

    // A line is won when fully occupied and its colours are all-0 or all-1.
    always_comb begin
        line_mask = mask_of(line_q);
        line_col  = |(snap_col_q & line_mask);
        line_won  = ((snap_occ_q & line_mask) == line_mask) &&
                    (((snap_col_q & line_mask) == line_mask) ||
                     ((snap_col_q & line_mask) == 9'h000));
    end

    always_comb begin
        state_d        = state_q;
        snap_occ_d     = snap_occ_q;
        snap_col_d     = snap_col_q;
        line_d         = line_q;
        hold_d         = hold_q;
        move_pulse_d   = 1'b0;
        move_cnt_d     = move_cnt_q;
        winner_valid_d = winner_valid_q;
        winner_d       = winner_q;
        win_line_d     = win_line_q;
        draw_d         = draw_q;
        game_over_d    = game_over_q;

        if (!start_en) begin
            // Dropping start_en aborts whatever is running and wipes the game.
            state_d        = S_IDLE;
            snap_occ_d     = '0;
            snap_col_d     = '0;
            line_d         = '0;
            hold_d         = '0;
            move_cnt_d     = '0;
            winner_valid_d = 1'b0;
            winner_d       = 1'b0;
            win_line_d     = '0;
            draw_d         = 1'b0;
            game_over_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_WAIT;
                S_WAIT: begin
                    if (square1to9 != snap_occ_q) begin
                        snap_occ_d   = square1to9;
                        snap_col_d   = square1to9_color;
                        move_cnt_d   = popcount9(square1to9);
                        move_pulse_d = 1'b1;
                        line_d       = '0;
                        state_d      = S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (line_won) begin
                        winner_valid_d = 1'b1;
                        winner_d       = line_col;
                        win_line_d     = line_q;
                        hold_d         = '0;
                        state_d        = S_HOLD;
                    end else if (line_q == LAST_LINE) begin
                        if (move_cnt_q == 4'd9) begin
                            draw_d  = 1'b1;
                            hold_d  = '0;
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        line_d = line_q + 3'd1;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        game_over_d = 1'b1;
                        state_d     = S_OVER;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                S_OVER:  state_d = S_OVER;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            snap_occ_q     <= '0;
            snap_col_q     <= '0;
            line_q         <= '0;
            hold_q         <= '0;
            move_pulse_q   <= 1'b0;
            move_cnt_q     <= '0;
            winner_valid_q <= 1'b0;
            winner_q       <= 1'b0;
            win_line_q     <= '0;
            draw_q         <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            snap_occ_q     <= snap_occ_d;
            snap_col_q     <= snap_col_d;
            line_q         <= line_d;
            hold_q         <= hold_d;
            move_pulse_q   <= move_pulse_d;
            move_cnt_q     <= move_cnt_d;
            winner_valid_q <= winner_valid_d;
            winner_q       <= winner_d;
            win_line_q     <= win_line_d;
            draw_q         <= draw_d;
            game_over_q    <= game_over_d;
        end
    end

    assign move_pulse   = move_pulse_q;
    assign move_cnt     = move_cnt_q;
    assign busy         = (state_q == S_SCAN) || (state_q == S_HOLD);
    assign winner_valid = winner_valid_q;
    assign winner       = winner_q;
    assign win_line     = win_line_q;
    assign draw         = draw_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_game_judge.sv
// Bench for game_judge: hand-made board vectors, corner-case sequences and
// random games, all checked against a line-table model of the rules.
module tb_game_judge;

    localparam int WIN_HOLD = 4;

    logic       pclk;
    logic       rst;
    logic       start_en;
    logic [8:0] square1to9;
    logic [8:0] square1to9_color;
    logic       move_pulse;
    logic [3:0] move_cnt;
    logic       busy;
    logic       winner_valid;
    logic       winner;
    logic [2:0] win_line;
    logic       draw;
    logic       game_over;

    game_judge #(.WIN_HOLD(WIN_HOLD)) dut (
        .pclk             (pclk),
        .rst              (rst),
        .start_en         (start_en),
        .square1to9       (square1to9),
        .square1to9_color (square1to9_color),
        .move_pulse       (move_pulse),
        .move_cnt         (move_cnt),
        .busy             (busy),
        .winner_valid     (winner_valid),
        .winner           (winner),
        .win_line         (win_line),
        .draw             (draw),
        .game_over        (game_over)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int lt [8][3];
    logic [8:0] cur_occ;
    bit over;

    typedef struct {
        logic [8:0] occ;
        logic [8:0] col;
        bit         won;
        int         line;
        bit         wcol;
        bit         drw;
        string      name;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int outs_all();
        return int'({move_pulse, move_cnt, busy, winner_valid, winner, win_line, draw, game_over});
    endfunction

    // Reference: lowest-numbered fully occupied single-colour line wins;
    // otherwise a full board is a draw.
    function automatic void judge(input logic [8:0] occ, input logic [8:0] col,
                                  output bit won, output int ln, output bit wc, output bit drw);
        won = 0; ln = 0; wc = 0;
        for (int k = 7; k >= 0; k--) begin
            int a, b, c;
            a = lt[k][0]; b = lt[k][1]; c = lt[k][2];
            if (occ[a] && occ[b] && occ[c] && col[a] == col[b] && col[b] == col[c]) begin
                won = 1; ln = k; wc = col[a];
            end
        end
        drw = !won && ($countones(occ) == 9);
    endfunction

    task automatic run_move(input logic [8:0] occ, input logic [8:0] col, input bit e_won,
                            input int e_line, input bit e_col, input bit e_draw, input string tag);
        int n, exp_n;
        bit extra, done;
        @(negedge pclk);
        square1to9 = occ;
        square1to9_color = col;
        @(negedge pclk);
        chk({tag, ":pulse"}, int'(move_pulse), 1);
        chk({tag, ":cnt"}, int'(move_cnt), $countones(occ));
        n = 0; extra = 0; done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (busy) begin
                n++;
                @(negedge pclk);
                if (move_pulse) extra = 1;
            end else begin
                done = 1;
            end
        end
        chk({tag, ":busy_bounded"}, int'(done), 1);
        exp_n = (e_won ? e_line + 1 : 8) + ((e_won || e_draw) ? WIN_HOLD : 0);
        chk({tag, ":busy_len"}, n, exp_n);
        chk({tag, ":one_pulse"}, int'(extra), 0);
        chk({tag, ":winner_valid"}, int'(winner_valid), int'(e_won));
        if (e_won) begin
            chk({tag, ":winner"}, int'(winner), int'(e_col));
            chk({tag, ":win_line"}, int'(win_line), e_line);
        end
        chk({tag, ":draw"}, int'(draw), int'(e_draw));
        chk({tag, ":game_over"}, int'(game_over), int'(e_won || e_draw));
        over = e_won || e_draw;
        cur_occ = occ;
    endtask

    task automatic model_move(input logic [8:0] occ, input logic [8:0] col, input string tag);
        bit w, wc, d;
        int ln;
        judge(occ, col, w, ln, wc, d);
        run_move(occ, col, w, ln, wc, d, tag);
    endtask

    task automatic restart(input string tag);
        @(negedge pclk);
        start_en = 1'b0;
        @(negedge pclk);
        chk({tag, ":cleared"}, outs_all(), 0);
        square1to9 = '0;
        square1to9_color = '0;
        start_en = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        chk({tag, ":fresh"}, outs_all(), 0);
        cur_occ = '0;
        over = 0;
    endtask

    task automatic probe_over(input string tag);
        bit extra, lost;
        int wl;
        wl = int'(win_line);
        extra = 0; lost = 0;
        @(negedge pclk);
        square1to9 = ~cur_occ;
        square1to9_color = 9'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            if (move_pulse) extra = 1;
            if (!game_over || busy || int'(win_line) != wl) lost = 1;
        end
        chk({tag, ":over_no_pulse"}, int'(extra), 0);
        chk({tag, ":over_frozen"}, int'(lost), 0);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge pclk);
            if (!busy) done = 1;
        end
        chk({tag, ":idle_bounded"}, int'(done), 1);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        lt = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        vecs[0] = '{9'h001, 9'h000, 0, 0, 0, 0, "one_blue"};
        vecs[1] = '{9'h117, 9'h006, 1, 6, 0, 0, "diag_blue"};
        vecs[2] = '{9'h1FF, 9'h072, 0, 0, 0, 1, "full_draw"};
        vecs[3] = '{9'h04F, 9'h04F, 1, 0, 1, 0, "row0_col0_yellow"};
        vecs[4] = '{9'h1FF, 9'h1AB, 1, 7, 0, 0, "full_win_line7"};
        vecs[5] = '{9'h124, 9'h124, 1, 5, 1, 0, "col2_yellow"};

        rst = 1'b1;
        start_en = 1'b1;
        square1to9 = 9'h1FF;
        square1to9_color = 9'h0F0;
        cur_occ = '0;
        over = 0;
        repeat (3) @(negedge pclk);
        chk("reset_zero", outs_all(), 0);
        square1to9 = '0;
        square1to9_color = '0;
        rst = 1'b0;
        repeat (3) @(negedge pclk);
        chk("empty_wait_zero", outs_all(), 0);

        model_move(9'h001, 9'h000, "first_move");

        // Step-by-step game ending on the 0-4-8 diagonal.
        model_move(9'h003, 9'h002, "seq_m2");
        model_move(9'h013, 9'h002, "seq_m3");
        model_move(9'h017, 9'h006, "seq_m4");
        run_move(9'h117, 9'h006, 1, 6, 0, 0, "seq_win");
        probe_over("seq");
        restart("after_over");

        for (int v = 0; v < 6; v++) begin
            run_move(vecs[v].occ, vecs[v].col, vecs[v].won, vecs[v].line,
                     vecs[v].wcol, vecs[v].drw, vecs[v].name);
            restart({vecs[v].name, ":restart"});
        end

        // Moves made during a scan collapse into one later pulse.
        @(negedge pclk);
        square1to9 = 9'h001;
        square1to9_color = 9'h000;
        @(negedge pclk);
        chk("collapse:first_pulse", int'(move_pulse), 1);
        square1to9 = 9'h083;
        square1to9_color = 9'h002;
        wait_idle("collapse:scan1");
        @(negedge pclk);
        chk("collapse:second_pulse", int'(move_pulse), 1);
        chk("collapse:cnt", int'(move_cnt), 3);
        wait_idle("collapse:scan2");
        chk("collapse:no_win", int'(winner_valid), 0);
        cur_occ = 9'h083;
        model_move(9'h082, 9'h002, "bit_clear");

        // Abort in the middle of a scan.
        restart("pre_abort");
        @(negedge pclk);
        square1to9 = 9'h007;
        square1to9_color = 9'h000;
        repeat (3) @(negedge pclk);
        chk("abort:busy", int'(busy), 1);
        start_en = 1'b0;
        @(negedge pclk);
        chk("abort:zero", outs_all(), 0);
        restart("abort");
        run_move(9'h007, 9'h000, 1, 0, 0, 0, "abort:fresh_game");
        restart("abort:after");

        // Random alternating-colour games.
        for (int g = 0; g < 25; g++) begin
            int perm [9];
            logic [8:0] occ, col;
            bit c;
            for (int i = 0; i < 9; i++) perm[i] = i;
            for (int i = 8; i > 0; i--) begin
                int j, t;
                j = int'($urandom_range(0, i));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            occ = '0; col = '0;
            c = 1'($urandom_range(0, 1));
            for (int m = 0; m < 9 && !over; m++) begin
                occ[perm[m]] = 1'b1;
                col[perm[m]] = c;
                c = ~c;
                model_move(occ, col, $sformatf("game%0d_m%0d", g, m));
            end
            probe_over($sformatf("game%0d", g));
            restart($sformatf("game%0d", g));
        end

        // Random arbitrary boards, including bits clearing.
        for (int r = 0; r < 40; r++) begin
            logic [8:0] occ, col;
            occ = 9'($urandom);
            col = 9'($urandom) & occ;
            if (occ == cur_occ) occ = occ ^ 9'h001;
            model_move(occ, col, $sformatf("rand%0d", r));
            if (over) restart($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
